pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, giving the payload width in bits.
REQ-002 The block SHALL have parameter NOP_VAL, default all-zero DATA_W-bit value, giving the payload presented while the stage is empty.
REQ-003 The block SHALL have parameter SKID, default 1: 1 selects 2-entry skid mode; 0 selects 1-entry mode.
REQ-004 Reset SHALL be rst, asynchronous, active-high; the clock SHALL be clk.
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept a payload
- in_data  in  DATA_W  upstream payload
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_data  out  DATA_W  head payload; NOP_VAL when empty
- occupancy  out  2  number of held entries (0..2)

Function
REQ-006 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; a retire SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-007 Entries SHALL retire in strict acceptance order; no payload SHALL be duplicated or dropped except by flush.
REQ-008 Latency SHALL be one cycle: a payload accepted into an empty stage SHALL appear on out_valid/out_data after the next edge.
REQ-009 SKID=1: state EMPTY(0), HALF(1) or FULL(2); in_ready SHALL be a registered signal equal to (occupancy != 2), with no combinational path from out_ready.
REQ-010 SKID=1 transitions:
- EMPTY+accept -> HALF
- HALF+accept, no retire -> FULL
- HALF+retire, no accept -> EMPTY
- HALF+accept+retire -> HALF (new payload at head)
- FULL+retire -> HALF (skid entry moves to head)
- all other cases hold state
REQ-011 SKID=0: in_ready SHALL equal (!out_valid || out_ready), combinationally; occupancy SHALL never exceed 1; accept+retire in the same cycle SHALL replace the head.
REQ-012 When flush=1 at an edge, both entries SHALL be invalidated, occupancy SHALL become 0, and out_data SHALL become NOP_VAL; any same-cycle accept SHALL be discarded and any same-cycle retire still counts downstream.
REQ-013 When the stage is empty, out_data SHALL equal NOP_VAL (bubble insertion), so downstream decode of a non-valid slot sees a NOP.
REQ-014 Payload registers SHALL be unchanged while the stage is stalled (out_valid=1, out_ready=0, no flush).
REQ-015 in_data SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.
REQ-016 occupancy SHALL always equal the number of valid held entries after each edge.

Reset
REQ-017 While rst=1: out_valid=0, out_data=NOP_VAL, occupancy=0, skid entry invalid, in_ready=1 (SKID=1 registered value).
REQ-018 Reset asserted mid-operation SHALL discard all entries immediately without waiting for a clock edge; the first edge after release SHALL behave as from EMPTY.

Verification
REQ-019 Streaming: SKID=1, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, occupancy steady 1, in_ready steady 1.
REQ-020 Backpressure: out_ready=0, accept 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; then out_ready=1 -> 0xA, then 0xB retire, and no third payload is accepted while in_ready=0.
REQ-021 Flush: FULL holding 0xA/0xB, flush=1 with in_valid=1 data 0xC -> next cycle occupancy 0, out_valid=0, out_data=NOP_VAL; 0xC never appears.
REQ-022 SKID=0: head 0x5 valid with out_ready=1 and in_valid=1 data 0x6 -> in_ready=1 same cycle, next cycle out_data=0x6, occupancy 1.
REQ-023 Async reset: rst pulsed between edges while FULL -> out_valid=0 and occupancy=0 before the next edge, out_data=NOP_VAL.
REQ-024 Random valid/ready/flush for 10k cycles against a scoreboard queue -> in-order delivery, no loss outside flush, occupancy always consistent.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional skid entry.
// SKID=1: two entries (head + skid), in_ready is registered and does not
// depend on out_ready combinationally. SKID=0: a single head entry whose
// in_ready is combinational (!out_valid || out_ready).
// The head payload register holds NOP_VAL whenever the stage is empty, so
// out_data presents a bubble to downstream decode without an output mux.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W  = 128,
   parameter logic [DATA_W-1:0] NOP_VAL = '0,
   parameter int unsigned       SKID    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // Encoding equals the number of held entries, so occupancy is the state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              accept;
   logic              retire;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_q;
   assign occupancy = state_q;
   assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign retire    = out_valid && out_ready;

   // Next-state and payload steering for accept/retire/flush.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         // A same-cycle accept is dropped; a same-cycle retire already
         // happened downstream and needs nothing from us.
         state_d = EMPTY;
         head_d  = NOP_VAL;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = HALF;
                  head_d  = in_data;
               end
            end
            HALF: begin
               if (accept && retire) begin
                  head_d = in_data;
               end else if (accept) begin
                  // Only reachable with SKID=1: in 1-entry mode an accept
                  // while holding an entry implies a retire.
                  if (SKID != 0) begin
                     state_d = FULL;
                     skid_d  = in_data;
                  end
               end else if (retire) begin
                  state_d = EMPTY;
                  head_d  = NOP_VAL;
               end
            end
            FULL: begin
               // in_ready is low here, so the only event is a retire.
               if (retire) begin
                  state_d = HALF;
                  head_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
               head_d  = NOP_VAL;
            end
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   // State, payload and registered ready; async reset empties the stage.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments; payload registers are reset too because out_data must read NOP_VAL while empty.
      if (rst) begin
         state_q    <= EMPTY;
         head_q     <= NOP_VAL;
         skid_q     <= NOP_VAL;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule
